// File: rtl/unit_mul_rs_param.sv
// Multiply unit: NUM_RS reservation stations, LATENCY-stage multiplier and an OUT_DEPTH
// result FIFO toward the CDB. State updates on the falling clock edge.
module unit_mul_rs_param #(
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          NUM_RS    = 3,
  parameter int unsigned          FU_TAG_W  = 5,
  parameter logic [FU_TAG_W-1:0]  FU_TAG    = 5'b00010,
  parameter int unsigned          LATENCY   = 3,
  parameter int unsigned          OUT_DEPTH = 2,
  localparam int unsigned         QW        = FU_TAG_W + NUM_RS,
  localparam int unsigned         CW        = 1 + QW + DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic [1:0]        op_in,
  input  logic [QW-1:0]     q1_in,
  input  logic [QW-1:0]     q2_in,
  input  logic [DATA_W-1:0] v1_in,
  input  logic [DATA_W-1:0] v2_in,
  input  logic [CW-1:0]     cdb,
  output logic              all_busy,
  output logic [QW-1:0]     issue_tag,
  output logic              cdb_request,
  output logic [CW-2:0]     cdb_out
);
  localparam int unsigned IW  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int unsigned PW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CNW = $clog2(OUT_DEPTH + 1);

  logic [NUM_RS-1:0] busy, disp;
  logic [1:0]        op_r  [NUM_RS];
  logic [QW-1:0]     q1_r  [NUM_RS];
  logic [QW-1:0]     q2_r  [NUM_RS];
  logic [DATA_W-1:0] v1_r  [NUM_RS];
  logic [DATA_W-1:0] v2_r  [NUM_RS];
  logic [IW-1:0]     age_r [NUM_RS];

  logic [LATENCY-1:0] pv;
  logic [NUM_RS-1:0]  prs  [LATENCY];
  logic [DATA_W-1:0]  pdat [LATENCY];

  logic [NUM_RS-1:0]  f_rs  [OUT_DEPTH];
  logic [DATA_W-1:0]  f_dat [OUT_DEPTH];
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic [CNW-1:0]     f_cnt;

  logic                cdb_on;
  logic [QW-1:0]       cdb_tag;
  logic [FU_TAG_W-1:0] cdb_fu;
  logic [NUM_RS-1:0]   cdb_rs;
  logic [DATA_W-1:0]   cdb_data;

  assign cdb_on   = cdb[CW-1];
  assign cdb_tag  = cdb[CW-2:DATA_W];
  assign cdb_fu   = cdb_tag[QW-1:NUM_RS];
  assign cdb_rs   = cdb_tag[NUM_RS-1:0];
  assign cdb_data = cdb[DATA_W-1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic              accept, byp1, byp2, grant;
  logic [NUM_RS-1:0] issue_oh, free_oh, disp_oh;

  assign all_busy  = &busy;
  assign accept    = issue & ~all_busy;
  assign issue_tag = accept ? {FU_TAG, issue_oh} : '0;
  assign byp1      = cdb_on && (q1_in != '0) && (cdb_tag == q1_in);
  assign byp2      = cdb_on && (q2_in != '0) && (cdb_tag == q2_in);

  assign cdb_request = (f_cnt != '0);
  assign grant   = cdb_on && cdb_request && (cdb_fu == FU_TAG) && (cdb_rs == f_rs[rd_ptr]);
  assign free_oh = grant ? f_rs[rd_ptr] : '0;
  assign cdb_out = cdb_request ? {FU_TAG, f_rs[rd_ptr], f_dat[rd_ptr]}
                               : {FU_TAG, {NUM_RS{1'b0}}, {DATA_W{1'b0}}};

  always_comb begin
    issue_oh = '0;
    for (int unsigned i = 0; i < NUM_RS; i++)
      if (!busy[i] && issue_oh == '0) issue_oh[i] = 1'b1;
    if (!accept) issue_oh = '0;
  end

  // Age 0 is the oldest busy entry; the winner is the ready entry with the smallest age.
  logic [IW-1:0] free_age, new_age, best_age, sel_idx;
  logic          sel_found, can_disp;
  int unsigned   occ;

  always_comb begin
    free_age  = '0;
    new_age   = '0;
    best_age  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    occ       = 32'(f_cnt);
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      if (free_oh[i]) free_age = age_r[i];
      if (busy[i]) new_age = new_age + IW'(1);
      if (busy[i] && !disp[i] && q1_r[i] == '0 && q2_r[i] == '0 &&
          (!sel_found || age_r[i] < best_age)) begin
        sel_found = 1'b1;
        best_age  = age_r[i];
        sel_idx   = IW'(i);
      end
    end
    if (grant) new_age = new_age - IW'(1);
    for (int unsigned s = 0; s < LATENCY; s++) occ = occ + 32'(pv[s]);
    can_disp = sel_found && (occ < OUT_DEPTH);
    disp_oh  = '0;
    if (can_disp) disp_oh[sel_idx] = 1'b1;
  end

  logic [1:0]          d_op;
  logic [DATA_W-1:0]   d_a, d_b, d_res;
  logic [2*DATA_W-1:0] ext_a, ext_b, prod;

  // Sign-extending to 2*DATA_W makes the truncated unsigned product exact for every mode.
  assign d_op  = op_r[sel_idx];
  assign d_a   = v1_r[sel_idx];
  assign d_b   = v2_r[sel_idx];
  assign ext_a = {{DATA_W{(d_op == 2'd1 || d_op == 2'd2) & d_a[DATA_W-1]}}, d_a};
  assign ext_b = {{DATA_W{(d_op == 2'd1) & d_b[DATA_W-1]}}, d_b};
  assign prod  = ext_a * ext_b;
  assign d_res = (d_op == 2'd0) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      busy   <= '0;
      disp   <= '0;
      pv     <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      f_cnt  <= '0;
      for (int unsigned i = 0; i < NUM_RS; i++) begin
        op_r[i]  <= '0;
        q1_r[i]  <= '0;
        q2_r[i]  <= '0;
        v1_r[i]  <= '0;
        v2_r[i]  <= '0;
        age_r[i] <= '0;
      end
      for (int unsigned s = 0; s < LATENCY; s++) begin
        prs[s]  <= '0;
        pdat[s] <= '0;
      end
      for (int unsigned d = 0; d < OUT_DEPTH; d++) begin
        f_rs[d]  <= '0;
        f_dat[d] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_RS; i++) begin
        if (free_oh[i]) begin
          busy[i] <= 1'b0;
          disp[i] <= 1'b0;
        end else if (busy[i]) begin
          if (grant && age_r[i] > free_age) age_r[i] <= age_r[i] - IW'(1);
          if (q1_r[i] != '0 && cdb_on && cdb_tag == q1_r[i]) begin
            q1_r[i] <= '0;
            v1_r[i] <= cdb_data;
          end
          if (q2_r[i] != '0 && cdb_on && cdb_tag == q2_r[i]) begin
            q2_r[i] <= '0;
            v2_r[i] <= cdb_data;
          end
          if (disp_oh[i]) disp[i] <= 1'b1;
        end else if (issue_oh[i]) begin
          busy[i]  <= 1'b1;
          disp[i]  <= 1'b0;
          op_r[i]  <= op_in;
          age_r[i] <= new_age;
          q1_r[i]  <= byp1 ? '0 : q1_in;
          q2_r[i]  <= byp2 ? '0 : q2_in;
          v1_r[i]  <= byp1 ? cdb_data : v1_in;
          v2_r[i]  <= byp2 ? cdb_data : v2_in;
        end
      end
      pv[0]   <= can_disp;
      prs[0]  <= disp_oh;
      pdat[0] <= d_res;
      for (int unsigned s = 1; s < LATENCY; s++) begin
        pv[s]   <= pv[s-1];
        prs[s]  <= prs[s-1];
        pdat[s] <= pdat[s-1];
      end
      if (pv[LATENCY-1]) begin
        f_rs[wr_ptr]  <= prs[LATENCY-1];
        f_dat[wr_ptr] <= pdat[LATENCY-1];
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (grant) rd_ptr <= ptr_inc(rd_ptr);
      f_cnt <= f_cnt + CNW'(pv[LATENCY-1]) - CNW'(grant);
    end
  end
endmodule
